// File: rtl/cw310_ddr3_test_seq.sv
// DDR3 memory test sequencer on the MIG app_* interface (ui_clk domain).
// Each iteration writes an address/iteration pattern over the region, reads it back and checks it.
module cw310_ddr3_test_seq #(
  parameter int                     pDATA_WIDTH = 128,
  parameter int                     pADDR_WIDTH = 28,
  parameter int                     pADDR_INC   = 8,
  parameter logic [pADDR_WIDTH-1:0] pLAST_ADDR  = 28'hFFFFF8
) (
  input  logic                   ui_clk,
  input  logic                   reset_i,
  input  logic                   I_calib_done,
  input  logic                   I_en,
  input  logic                   I_clear_fail,
  output logic                   app_en,
  output logic [2:0]             app_cmd,
  output logic [pADDR_WIDTH-1:0] app_addr,
  input  logic                   app_rdy,
  output logic                   app_wdf_wren,
  output logic                   app_wdf_end,
  output logic [pDATA_WIDTH-1:0] app_wdf_data,
  input  logic                   app_wdf_rdy,
  input  logic [pDATA_WIDTH-1:0] app_rd_data,
  input  logic                   app_rd_data_valid,
  output logic [6:0]             O_stat,
  output logic                   O_pass,
  output logic                   O_fail,
  output logic [15:0]            O_iteration,
  output logic [7:0]             O_errors,
  output logic [pADDR_WIDTH-1:0] O_error_addr,
  output logic [15:0]            O_max_write_stall,
  output logic [15:0]            O_max_read_stall
);

  localparam int                     LANES    = pDATA_WIDTH / 32;
  localparam logic [pADDR_WIDTH-1:0] ADDR_INC = pADDR_WIDTH'(pADDR_INC);
  localparam logic [pADDR_WIDTH-1:0] ADDR_ONE = pADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [pADDR_WIDTH-1:0] wr_addr, rd_addr, chk_addr, outstanding;
  logic                   cmd_acc, dat_acc, full_read;
  logic [7:0]             iter_err;
  logic [15:0]            wr_run, rd_run;
  logic                   run, cmd_fire, dat_fire, burst_done, rd_fire;
  logic                   wr_stall, rd_stall, mismatch, enter_read;

  // Address word xor'd with the iteration count, replicated across all 32-bit lanes.
  function automatic logic [pDATA_WIDTH-1:0] pattern(input logic [pADDR_WIDTH-1:0] addr,
                                                     input logic [15:0] iter);
    logic [31:0] w;
    w = 32'(addr) ^ {iter, iter};
    return {LANES{w}};
  endfunction

  assign run        = I_en & I_calib_done;
  assign cmd_fire   = app_en & app_rdy;
  assign dat_fire   = app_wdf_wren & app_wdf_rdy;
  assign rd_fire    = (state == S_READ) & cmd_fire;
  assign burst_done = (state == S_WRITE) & (cmd_acc | cmd_fire) & (dat_acc | dat_fire);
  assign wr_stall   = (state == S_WRITE) & ((app_en & ~app_rdy) | (app_wdf_wren & ~app_wdf_rdy));
  assign rd_stall   = (state == S_READ) & app_en & ~app_rdy;
  assign mismatch   = app_rd_data_valid & (app_rd_data != pattern(chk_addr, O_iteration));
  assign enter_read = (state == S_WRITE) & (state_nxt == S_READ);

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = pattern(wr_addr, O_iteration);
  assign O_stat       = {I_calib_done, I_en, 2'b00, state};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (run) state_nxt = S_WRITE;
      S_WRITE: if (burst_done) begin
                 if (!run)                       state_nxt = S_IDLE;
                 else if (wr_addr == pLAST_ADDR) state_nxt = S_READ;
               end
      S_READ:  if (rd_fire && (rd_addr == pLAST_ADDR || !run)) state_nxt = S_DRAIN;
      S_DRAIN: if (outstanding == '0) state_nxt = full_read ? S_DONE : S_IDLE;
      S_DONE:  state_nxt = run ? S_WRITE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    app_en       = 1'b0;
    app_cmd      = 3'b000;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    unique case (state)
      S_WRITE: begin
        app_en       = ~cmd_acc;
        app_addr     = wr_addr;
        app_wdf_wren = ~dat_acc;
      end
      S_READ: begin
        app_en   = 1'b1;
        app_cmd  = 3'b001;
        app_addr = rd_addr;
      end
      default: ;
    endcase
  end

  // Command/data channels of a write burst are accepted independently.
  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_addr     <= '0;
      cmd_acc     <= 1'b0;
      dat_acc     <= 1'b0;
      rd_addr     <= '0;
      chk_addr    <= '0;
      full_read   <= 1'b0;
      outstanding <= '0;
    end else begin
      if (state == S_WRITE) begin
        if (burst_done) begin
          cmd_acc <= 1'b0;
          dat_acc <= 1'b0;
          wr_addr <= wr_addr + ADDR_INC;
        end else begin
          if (cmd_fire) cmd_acc <= 1'b1;
          if (dat_fire) dat_acc <= 1'b1;
        end
      end else begin
        cmd_acc <= 1'b0;
        dat_acc <= 1'b0;
        if (state == S_IDLE || state == S_DONE) wr_addr <= '0;
      end

      if (enter_read) begin
        rd_addr   <= '0;
        full_read <= 1'b0;
      end else if (rd_fire) begin
        rd_addr <= rd_addr + ADDR_INC;
        if (rd_addr == pLAST_ADDR) full_read <= 1'b1;
      end

      if (enter_read)             chk_addr <= '0;
      else if (app_rd_data_valid) chk_addr <= chk_addr + ADDR_INC;

      unique case ({rd_fire, app_rd_data_valid})
        2'b10:   outstanding <= outstanding + ADDR_ONE;
        2'b01:   outstanding <= outstanding - ADDR_ONE;
        default: ;
      endcase
    end
  end

  // Iteration bookkeeping and error reporting; a clear wins over a same-cycle mismatch.
  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) begin
      O_iteration  <= '0;
      O_pass       <= 1'b0;
      iter_err     <= '0;
      O_fail       <= 1'b0;
      O_errors     <= '0;
      O_error_addr <= '0;
    end else begin
      if (state == S_DONE) begin
        O_iteration <= O_iteration + 16'd1;
        O_pass      <= (iter_err == 8'd0);
        iter_err    <= '0;
      end else if (mismatch && iter_err != 8'hFF) begin
        iter_err <= iter_err + 8'd1;
      end

      if (I_clear_fail) begin
        O_fail       <= 1'b0;
        O_errors     <= '0;
        O_error_addr <= '0;
      end else if (mismatch) begin
        O_fail <= 1'b1;
        if (O_errors == 8'd0)  O_error_addr <= chk_addr;
        if (O_errors != 8'hFF) O_errors     <= O_errors + 8'd1;
      end
    end
  end

  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_run            <= '0;
      rd_run            <= '0;
      O_max_write_stall <= '0;
      O_max_read_stall  <= '0;
    end else begin
      if (wr_stall) begin
        if (wr_run != 16'hFFFF) wr_run <= wr_run + 16'd1;
      end else if (burst_done) begin
        wr_run <= '0;
      end

      if (rd_stall) begin
        if (rd_run != 16'hFFFF) rd_run <= rd_run + 16'd1;
      end else if (rd_fire) begin
        rd_run <= '0;
      end

      if (I_clear_fail) begin
        O_max_write_stall <= '0;
        O_max_read_stall  <= '0;
      end else begin
        if (wr_run > O_max_write_stall) O_max_write_stall <= wr_run;
        if (rd_run > O_max_read_stall)  O_max_read_stall  <= rd_run;
      end
    end
  end

endmodule

// File: tb/tb_cw310_ddr3_test_seq.sv
// Directed bench for cw310_ddr3_test_seq with a small MIG model: 4-word region, reads echo 4 cycles after accept.
module tb_cw310_ddr3_test_seq;

  logic         ui_clk = 1'b0;
  logic         reset_i;
  logic         I_calib_done, I_en, I_clear_fail;
  logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr, O_error_addr;
  logic [127:0] app_wdf_data, app_rd_data;
  logic [6:0]   O_stat;
  logic         O_pass, O_fail;
  logic [15:0]  O_iteration, O_max_write_stall, O_max_read_stall;
  logic [7:0]   O_errors;
  logic [2:0]   dut_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ui_clk = ~ui_clk;
  assign dut_state = O_stat[2:0];

  cw310_ddr3_test_seq #(
    .pDATA_WIDTH(128), .pADDR_WIDTH(28), .pADDR_INC(8), .pLAST_ADDR(28'd24)
  ) dut (
    .ui_clk(ui_clk), .reset_i(reset_i), .I_calib_done(I_calib_done), .I_en(I_en),
    .I_clear_fail(I_clear_fail), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rdy(app_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .O_stat(O_stat), .O_pass(O_pass), .O_fail(O_fail),
    .O_iteration(O_iteration), .O_errors(O_errors), .O_error_addr(O_error_addr),
    .O_max_write_stall(O_max_write_stall), .O_max_read_stall(O_max_read_stall)
  );

  // ---------------- MIG model ----------------
  typedef struct {int due; logic [27:0] addr;} rd_req_t;

  rd_req_t      rq[$];
  logic [27:0]  wa_q[$];
  logic [127:0] wd_q[$];
  logic [27:0]  wr_log[$];
  logic [127:0] mem [4];
  int cyc = 0, n_wr = 0, n_wr_cmd = 0, n_wr_dat = 0, n_rd = 0, n_rv = 0;
  int cmd_stall_idx = -1, cmd_stall_len = 0, cmd_stall_cnt = 0;
  int dat_stall_idx = -1, dat_stall_len = 0, dat_stall_cnt = 0;
  logic corrupt_one = 1'b0, corrupt_all = 1'b0;

  assign app_rdy = !(app_en && app_cmd == 3'b000 && n_wr_cmd == cmd_stall_idx &&
                     cmd_stall_cnt < cmd_stall_len);
  assign app_wdf_rdy = !(app_wdf_wren && n_wr_dat == dat_stall_idx && dat_stall_cnt < dat_stall_len);

  function automatic logic [127:0] rd_value(input logic [27:0] a);
    logic [127:0] d;
    d = mem[a[4:3]];
    if (corrupt_all || (corrupt_one && a == 28'd16)) d[0] = ~d[0];
    return d;
  endfunction

  initial begin
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
  end

  always @(posedge ui_clk) begin
    cyc <= cyc + 1;
    if (app_en && !app_rdy && app_cmd == 3'b000) cmd_stall_cnt <= cmd_stall_cnt + 1;
    if (app_wdf_wren && !app_wdf_rdy)            dat_stall_cnt <= dat_stall_cnt + 1;
    if (app_en && app_rdy && app_cmd == 3'b000) begin
      wa_q.push_back(app_addr);
      n_wr_cmd <= n_wr_cmd + 1;
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      wd_q.push_back(app_wdf_data);
      n_wr_dat <= n_wr_dat + 1;
    end
    if (wa_q.size() > 0 && wd_q.size() > 0) begin
      mem[wa_q[0][4:3]] <= wd_q[0];
      wr_log.push_back(wa_q[0]);
      n_wr <= n_wr + 1;
      wa_q.delete(0);
      wd_q.delete(0);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      app_rd_data_valid <= 1'b1;
      app_rd_data       <= rd_value(rq[0].addr);
      n_rv              <= n_rv + 1;
      rq.delete(0);
    end else begin
      app_rd_data_valid <= 1'b0;
    end
    if (app_en && app_rdy && app_cmd == 3'b001) begin
      rq.push_back('{due: cyc + 4, addr: app_addr});
      n_rd <= n_rd + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    int n = 0;
    while (dut_state !== s && n < budget) begin
      @(negedge ui_clk);
      n++;
    end
    check(tag, 128'(dut_state), 128'(s));
  endtask

  // One full iteration, then en drops during DRAIN so the sequencer settles in IDLE.
  task automatic run_one(input string tag);
    I_en = 1'b1;
    wait_state({tag, "_drain"}, 3'd3, 200);
    I_en = 1'b0;
    wait_state({tag, "_idle"}, 3'd0, 200);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int snap_wr, snap_rd, snap_rv, n;
    reset_i = 1'b1; I_calib_done = 1'b1; I_en = 1'b0; I_clear_fail = 1'b0;
    repeat (3) @(negedge ui_clk);
    reset_i = 1'b0;
    @(negedge ui_clk);

    // reset state
    check("rst_app_en", 128'(app_en), 128'd0);
    check("rst_wren", 128'(app_wdf_wren), 128'd0);
    check("rst_state", 128'(dut_state), 128'd0);
    check("rst_pass", 128'(O_pass), 128'd0);
    check("rst_fail", 128'(O_fail), 128'd0);
    check("rst_iter", 128'(O_iteration), 128'd0);
    check("rst_errors", 128'(O_errors), 128'd0);

    // 1. one clean iteration (pattern = address, iteration 0)
    run_one("t1");
    check("t1_n_wr", 128'(n_wr), 128'd4);
    check("t1_wr_addr0", 128'(wr_log[0]), 128'd0);
    check("t1_wr_addr1", 128'(wr_log[1]), 128'd8);
    check("t1_wr_addr2", 128'(wr_log[2]), 128'd16);
    check("t1_wr_addr3", 128'(wr_log[3]), 128'd24);
    check("t1_wdata16", mem[2], {4{32'h0000_0010}});
    check("t1_n_rd", 128'(n_rd), 128'd4);
    check("t1_iter", 128'(O_iteration), 128'd1);
    check("t1_pass", 128'(O_pass), 128'd1);
    check("t1_fail", 128'(O_fail), 128'd0);

    // 2. single corrupted word at addr 16, then a clean iteration
    corrupt_one = 1'b1;
    run_one("t2a");
    corrupt_one = 1'b0;
    check("t2_errors", 128'(O_errors), 128'd1);
    check("t2_err_addr", 128'(O_error_addr), 128'd16);
    check("t2_fail", 128'(O_fail), 128'd1);
    check("t2_pass", 128'(O_pass), 128'd0);
    run_one("t2b");
    check("t2_pass_clean", 128'(O_pass), 128'd1);
    check("t2_fail_sticky", 128'(O_fail), 128'd1);
    check("t2_iter", 128'(O_iteration), 128'd3);

    // 3. write stalls: app_rdy low 5 cycles on 2nd write, wdf_rdy low 3 cycles on 3rd
    snap_wr = n_wr;
    cmd_stall_idx = n_wr_cmd + 1; cmd_stall_len = 5;
    dat_stall_idx = n_wr_dat + 2; dat_stall_len = 3;
    run_one("t3");
    check("t3_max_wstall", 128'(O_max_write_stall), 128'd5);
    check("t3_max_rstall", 128'(O_max_read_stall), 128'd0);
    check("t3_n_wr", 128'(n_wr - snap_wr), 128'd4);
    check("t3_wdata8", mem[1], {4{32'h0003_000B}});
    check("t3_pass", 128'(O_pass), 128'd1);
    check("t3_errors", 128'(O_errors), 128'd1);

    // 4. en dropped in READ so the 2nd read accept sees it low
    snap_rd = n_rd; snap_rv = n_rv;
    I_en = 1'b1;
    n = 0;
    while (n_rd < snap_rd + 1 && n < 200) begin
      @(negedge ui_clk);
      n++;
    end
    I_en = 1'b0;
    wait_state("t4_idle", 3'd0, 200);
    repeat (8) @(negedge ui_clk);
    check("t4_n_rd", 128'(n_rd - snap_rd), 128'd2);
    check("t4_n_rv", 128'(n_rv - snap_rv), 128'd2);
    check("t4_state", 128'(dut_state), 128'd0);
    check("t4_iter", 128'(O_iteration), 128'd4);
    check("t4_errors", 128'(O_errors), 128'd1);

    // 5. clear, then 300 iterations of bad data
    I_clear_fail = 1'b1;
    @(negedge ui_clk);
    I_clear_fail = 1'b0;
    check("t5_clr_errors", 128'(O_errors), 128'd0);
    check("t5_clr_fail", 128'(O_fail), 128'd0);
    check("t5_clr_err_addr", 128'(O_error_addr), 128'd0);
    check("t5_clr_max_wstall", 128'(O_max_write_stall), 128'd0);
    corrupt_all = 1'b1;
    I_en = 1'b1;
    n = 0;
    while (O_iteration !== 16'd303 && n < 20000) begin
      @(negedge ui_clk);
      n++;
    end
    check("t5_iter_reach", 128'(O_iteration), 128'd303);
    wait_state("t5_drain", 3'd3, 200);
    I_en = 1'b0;
    wait_state("t5_idle", 3'd0, 200);
    check("t5_iter", 128'(O_iteration), 128'd304);
    check("t5_errors_sat", 128'(O_errors), 128'hFF);
    check("t5_err_addr", 128'(O_error_addr), 128'd0);
    check("t5_fail", 128'(O_fail), 128'd1);
    check("t5_pass", 128'(O_pass), 128'd0);

    // clear asserted in the same cycle as a mismatching read
    I_en = 1'b1;
    n = 0;
    while (app_rd_data_valid !== 1'b1 && n < 200) begin
      @(negedge ui_clk);
      n++;
    end
    check("t5_valid_seen", 128'(app_rd_data_valid), 128'd1);
    I_clear_fail = 1'b1;
    @(negedge ui_clk);
    I_clear_fail = 1'b0;
    check("t5_clrmm_errors", 128'(O_errors), 128'd0);
    check("t5_clrmm_fail", 128'(O_fail), 128'd0);
    check("t5_clrmm_err_addr", 128'(O_error_addr), 128'd0);
    I_en = 1'b0;
    wait_state("t5_clrmm_idle", 3'd0, 200);

    // 6. asynchronous reset in the middle of WRITE
    I_en = 1'b1;
    wait_state("t6_write", 3'd1, 200);
    #2 reset_i = 1'b1;
    #1;
    check("t6_app_en", 128'(app_en), 128'd0);
    check("t6_wren", 128'(app_wdf_wren), 128'd0);
    check("t6_state", 128'(dut_state), 128'd0);
    check("t6_iter", 128'(O_iteration), 128'd0);
    check("t6_errors", 128'(O_errors), 128'd0);
    check("t6_fail", 128'(O_fail), 128'd0);
    check("t6_pass", 128'(O_pass), 128'd0);
    I_en = 1'b0;
    @(negedge ui_clk);
    reset_i = 1'b0;
    @(negedge ui_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
